l1a_evt_queue: RTL and testbench

Event-tag queue directly downstream of the L1A/LCT match stage. It tags every L1A with an L1A number and bunch-crossing number, holds the tags until the match stage resolves each L1A (MATCHR or NO_MATCH), then presents resolved events to readout through a first-word-fall-through handshake. It supplies the event header fields that go with each matched or unmatched L1A.

---
 rtl/l1a_evt_queue.sv | 189 ++++++++++++++++++
 tb/tb_l1a_evt_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1a_evt_queue.sv
// ---------------------------------------------------------------------------
// l1a_evt_queue
//   Event-tag queue behind the L1A/LCT match stage. Each L1A is tagged with
//   {L1A number, BX number} and held in a tag queue until the match stage
//   resolves it. The resolved tag and its match flag then move to an event
//   queue, which readout drains through a first-word-fall-through handshake.
//
// Parameters
//   DEPTH  entries in each of the tag queue and the event queue
//          (power of 2, 4..64)
//   TMR    selects triplicated counter primitives; no functional effect
//
// Ports
//   CLK          in   system clock (40 MHz LHC clock)
//   RST_N        in   asynchronous active-low reset
//   L1A          in   one-cycle L1A strobe
//   BC0          in   bunch-crossing-zero strobe
//   MATCHR       in   resolution: L1A matched an LCT
//   NO_MATCH     in   resolution: L1A had no LCT
//   EVT_RD       in   readout pop request
//   EVT_VALID    out  event queue non-empty, head data valid
//   EVT_L1A_NUM  out  head L1A number
//   EVT_BX       out  head BX number
//   EVT_MATCH    out  head resolution (1 = matched)
//   EVT_CNT      out  event queue occupancy (0..DEPTH)
//   OVFL         out  sticky: a tag or an event was dropped
//   TAG_ERR      out  sticky: resolution protocol error
// ---------------------------------------------------------------------------
module l1a_evt_queue #(
  parameter int DEPTH = 8,
  parameter int TMR   = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     L1A,
  input  logic                     BC0,
  input  logic                     MATCHR,
  input  logic                     NO_MATCH,
  input  logic                     EVT_RD,
  output logic                     EVT_VALID,
  output logic [11:0]              EVT_L1A_NUM,
  output logic [11:0]              EVT_BX,
  output logic                     EVT_MATCH,
  output logic [$clog2(DEPTH):0]   EVT_CNT,
  output logic                     OVFL,
  output logic                     TAG_ERR
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);
  localparam logic [11:0]   BX_MAX = 12'd3563;

  typedef struct packed {
    logic [11:0] l1a;
    logic [11:0] bx;
  } tag_t;

  typedef struct packed {
    tag_t tag;
    logic match;
  } evt_t;

  // Counters are plain registers here; triplicated builds swap in the voted
  // counter primitive, so the parameter only selects implementation.
  if (TMR != 0) begin : g_tmr_passthru
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [11:0] r_bx;
  logic [11:0] r_l1a_cnt;

  tag_t        r_tag_mem [DEPTH];
  logic [AW-1:0] r_tag_wp, r_tag_rp;
  logic [AW:0]   r_tag_cnt;

  evt_t        r_evt_mem [DEPTH];
  logic [AW-1:0] r_evt_wp, r_evt_rp;
  logic [AW:0]   r_evt_cnt;

  logic        r_ovfl;
  logic        r_tag_err;

  // -------------------------------------------------------------------------
  // Queue control
  // -------------------------------------------------------------------------
  logic        w_resolve;
  logic        w_tag_empty, w_tag_full, w_tag_push, w_tag_pop, w_tag_drop;
  logic        w_evt_empty, w_evt_full, w_evt_push, w_evt_pop, w_evt_drop;
  logic        w_proto_err;
  logic [11:0] w_l1a_next;
  tag_t        w_new_tag;
  evt_t        w_new_evt;
  evt_t        w_head;

  assign w_resolve   = MATCHR | NO_MATCH;
  assign w_l1a_next  = r_l1a_cnt + 12'd1;

  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_full  = (r_tag_cnt == L_FULL);
  // No bypass: an L1A in the same cycle never satisfies a resolve on an
  // empty tag queue, but a resolve does free a slot for a same-cycle L1A.
  assign w_tag_pop   = w_resolve & ~w_tag_empty;
  assign w_tag_push  = L1A & (~w_tag_full | w_tag_pop);
  assign w_tag_drop  = L1A & ~w_tag_push;

  assign w_evt_empty = (r_evt_cnt == '0);
  assign w_evt_full  = (r_evt_cnt == L_FULL);
  assign w_evt_pop   = EVT_RD & ~w_evt_empty;
  assign w_evt_push  = w_resolve & (~w_evt_full | w_evt_pop);
  assign w_evt_drop  = w_resolve & ~w_evt_push;

  assign w_proto_err = w_resolve & (w_tag_empty | (MATCHR & NO_MATCH));

  assign w_new_tag   = '{l1a: w_l1a_next, bx: r_bx};
  // A resolve with nothing queued still produces an event, with zero tag.
  assign w_new_evt   = '{tag: (w_tag_empty ? '0 : r_tag_mem[r_tag_rp]),
                         match: MATCHR};

  // -------------------------------------------------------------------------
  // Counters, pointers, flags
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bx      <= '0;
      r_l1a_cnt <= '0;
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_tag_cnt <= '0;
      r_evt_wp  <= '0;
      r_evt_rp  <= '0;
      r_evt_cnt <= '0;
      r_ovfl    <= 1'b0;
      r_tag_err <= 1'b0;
    end else begin
      if (BC0 || r_bx == BX_MAX) r_bx <= '0;
      else                       r_bx <= r_bx + 12'd1;

      // L1A number advances even when the tag is dropped.
      if (L1A) r_l1a_cnt <= w_l1a_next;

      if (w_tag_push) r_tag_wp <= r_tag_wp + 1'b1;
      if (w_tag_pop)  r_tag_rp <= r_tag_rp + 1'b1;
      case ({w_tag_push, w_tag_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
        2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
        default: r_tag_cnt <= r_tag_cnt;
      endcase

      if (w_evt_push) r_evt_wp <= r_evt_wp + 1'b1;
      if (w_evt_pop)  r_evt_rp <= r_evt_rp + 1'b1;
      case ({w_evt_push, w_evt_pop})
        2'b10:   r_evt_cnt <= r_evt_cnt + 1'b1;
        2'b01:   r_evt_cnt <= r_evt_cnt - 1'b1;
        default: r_evt_cnt <= r_evt_cnt;
      endcase

      if (w_tag_drop || w_evt_drop) r_ovfl    <= 1'b1;
      if (w_proto_err)              r_tag_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the queue storage has no reset; occupancy counters define which
  // entries are meaningful and the head outputs are gated by EVT_VALID.
  always_ff @(posedge CLK) begin
    if (w_tag_push) r_tag_mem[r_tag_wp] <= w_new_tag;
    if (w_evt_push) r_evt_mem[r_evt_wp] <= w_new_evt;
  end

  // -------------------------------------------------------------------------
  // Outputs: all derived from registers only
  // -------------------------------------------------------------------------
  assign w_head      = w_evt_empty ? '0 : r_evt_mem[r_evt_rp];

  assign EVT_VALID   = ~w_evt_empty;
  assign EVT_L1A_NUM = w_head.tag.l1a;
  assign EVT_BX      = w_head.tag.bx;
  assign EVT_MATCH   = w_head.match;
  assign EVT_CNT     = r_evt_cnt;
  assign OVFL        = r_ovfl;
  assign TAG_ERR     = r_tag_err;

endmodule

// File: tb/tb_l1a_evt_queue.sv
// ---------------------------------------------------------------------------
// tb_l1a_evt_queue
//   Directed scenarios followed by randomized traffic. A queue-based model
//   predicts every event; a negedge monitor compares the DUT head against the
//   expected queue whenever an event is presented.
// ---------------------------------------------------------------------------
module tb_l1a_evt_queue;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       l1a, bc0, matchr, no_match, evt_rd;
  logic       evt_valid;
  logic [11:0] evt_l1a_num, evt_bx;
  logic       evt_match;
  logic [3:0] evt_cnt;
  logic       ovfl, tag_err;

  l1a_evt_queue #(.DEPTH(DEPTH), .TMR(0)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .L1A         (l1a),
    .BC0         (bc0),
    .MATCHR      (matchr),
    .NO_MATCH    (no_match),
    .EVT_RD      (evt_rd),
    .EVT_VALID   (evt_valid),
    .EVT_L1A_NUM (evt_l1a_num),
    .EVT_BX      (evt_bx),
    .EVT_MATCH   (evt_match),
    .EVT_CNT     (evt_cnt),
    .OVFL        (ovfl),
    .TAG_ERR     (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct { int l1a; int bx; } tag_m_t;
  typedef struct { int l1a; int bx; bit m; } ev_m_t;

  tag_m_t tag_q [$];
  ev_m_t  exp_q [$];
  int     m_bx, m_l1a;
  bit     m_ovfl, m_terr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs to the model; the model then describes the
  // state after the next clock edge.
  task automatic model_step(input bit b0, input bit la, input bit mr,
                            input bit nm, input bit rd);
    ev_m_t  ev;
    tag_m_t t;
    if (mr || nm) begin
      if (mr && nm) m_terr = 1;
      if (tag_q.size() == 0) begin
        m_terr = 1;
        ev = '{l1a: 0, bx: 0, m: mr};
      end else begin
        t  = tag_q.pop_front();
        ev = '{l1a: t.l1a, bx: t.bx, m: mr};
      end
      if (exp_q.size() < DEPTH || (rd && exp_q.size() > 0)) exp_q.push_back(ev);
      else m_ovfl = 1;
    end
    if (la) begin
      m_l1a = (m_l1a + 1) % 4096;
      if (tag_q.size() < DEPTH) tag_q.push_back('{l1a: m_l1a, bx: m_bx});
      else m_ovfl = 1;
    end
    m_bx = b0 ? 0 : (m_bx + 1) % 3564;
  endtask

  task automatic model_clear();
    tag_q.delete();
    exp_q.delete();
    m_bx = 0; m_l1a = 0; m_ovfl = 0; m_terr = 0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic cyc(input bit b0, input bit la, input bit mr,
                     input bit nm, input bit rd);
    @(posedge clk); #1;
    check("evt_cnt",   32'(evt_cnt),   32'(exp_q.size()));
    check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    check("ovfl",      32'(ovfl),      32'(m_ovfl));
    check("tag_err",   32'(tag_err),   32'(m_terr));
    bc0 = b0; l1a = la; matchr = mr; no_match = nm; evt_rd = rd;
    model_step(b0, la, mr, nm, rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    bc0 = 0; l1a = 0; matchr = 0; no_match = 0; evt_rd = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid",   32'(evt_valid),   32'd0);
    check("rst_cnt",     32'(evt_cnt),     32'd0);
    check("rst_ovfl",    32'(ovfl),        32'd0);
    check("rst_tag_err", 32'(tag_err),     32'd0);
    check("rst_l1a_num", 32'(evt_l1a_num), 32'd0);
    model_clear();
    @(negedge clk); #1 rst_n = 1'b1;
    // The edge following release runs with idle inputs.
    model_step(0, 0, 0, 0, 0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: compares the presented head with the expected queue front
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && evt_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", 32'(evt_valid), 32'd0);
      end else begin
        check("head_l1a",   32'(evt_l1a_num), 32'(exp_q[0].l1a));
        check("head_bx",    32'(evt_bx),      32'(exp_q[0].bx));
        check("head_match", 32'(evt_match),   32'(exp_q[0].m));
        if (evt_rd) void'(exp_q.pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    bc0 = 0; l1a = 0; matchr = 0; no_match = 0; evt_rd = 0;
    model_clear();

    // Basic tag / resolve / read: BX 9, L1A 1, matched.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    idle(9);
    cyc(0, 1, 0, 0, 0);
    idle(9);
    cyc(0, 0, 1, 0, 0);
    idle(4);
    cyc(0, 0, 0, 0, 1);
    idle(2);

    // BX wrap: tags at BX 3563 then 0.
    cyc(1, 0, 0, 0, 0);
    idle(3563);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    drain();

    // Tag queue overflow, then alternating resolutions.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, (i % 2) == 0, (i % 2) == 1, 0);
    drain();

    // Double resolution, then resolve on an empty tag queue.
    do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);   // same-cycle L1A on empty tag queue: no bypass
    cyc(0, 0, 1, 0, 0);
    drain();

    // Full event queue: resolve + read in one cycle.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    idle(1);
    // Full tag queue with same-cycle resolve accepts the new tag.
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 1);
    drain();

    // Reset mid-operation with 3 events queued.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    idle(1);
    do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    drain();

    // Randomized traffic in phases with different loading.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        bit b0, la, mr, nm, rd;
        int r;
        b0 = ($urandom_range(0, 99) < 2);
        la = ($urandom_range(0, 99) < 30 + 10 * ph);
        r  = $urandom_range(0, 99);
        mr = (r < 20) || (r >= 97 && ph > 1);
        nm = (r >= 20 && r < 35) || (r >= 97 && ph > 1);
        rd = ($urandom_range(0, 99) < 60 - 10 * ph);
        cyc(b0, la, mr, nm, rd);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
